// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared state encoding and default width for the bit-serial adder controller
package serial_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// rtl/serial_add_ctrl_if.sv - request/result bundle between a requesting FSM and serial_add_ctrl
//   master: start, a, b, cin, sub -> ; <- busy, done, sum, cout, ovf
//   slave : mirror of master
interface serial_add_ctrl_if
    import serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a, b, cin, sub,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, cin, sub,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_fa_bit.sv
// rtl/serial_fa_bit.sv - one-bit full adder with carry flop and previous-carry flop
//   Clk, Rst_n       : clock, async active-low reset
//   load, load_val   : preset carry before a new operation
//   en               : advance carry by one bit position
//   a, b -> s        : combinational sum bit using carry_q
//   carry_q          : running carry (final carry out once the last bit is done)
//   carry_in_q       : carry value before the most recent update (carry into MSB after the last bit)
module serial_fa_bit (
    input  logic Clk,
    input  logic Rst_n,
    input  logic load,
    input  logic load_val,
    input  logic en,
    input  logic a,
    input  logic b,
    output logic s,
    output logic carry_q,
    output logic carry_in_q
);
    logic carry_d;

    assign s       = a ^ b ^ carry_q;
    assign carry_d = (a & b) | (a & carry_q) | (b & carry_q);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            carry_q    <= 1'b0;
            carry_in_q <= 1'b0;
        end else if (load) begin
            carry_q    <= load_val;
            carry_in_q <= load_val;
        end else if (en) begin
            carry_in_q <= carry_q;
            carry_q    <= carry_d;
        end
    end
endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - sequencing controller for LSB-first bit-serial add/subtract
//   Clk, Rst_n : clock, async active-low reset
//   bus (slave): start/a/b/cin/sub request in; busy/done/sum/cout/ovf result out
module serial_add_ctrl
    import serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               Clk,
    input  logic               Rst_n,
    serial_add_ctrl_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             fa_load, fa_load_val, fa_en;
    logic             fa_s, carry_q, carry_in_q;

    serial_fa_bit u_fa (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .load       (fa_load),
        .load_val   (fa_load_val),
        .en         (fa_en),
        .a          (a_q[0]),
        .b          (b_q[0]),
        .s          (fa_s),
        .carry_q    (carry_q),
        .carry_in_q (carry_in_q)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        fa_load     = 1'b0;
        fa_en       = 1'b0;
        // Subtract is A + ~B + 1: the +1 rides in on the preset carry.
        fa_load_val = bus.sub ? 1'b1 : bus.cin;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    fa_load = 1'b1;
                    a_d     = bus.a;
                    b_d     = bus.b ^ {WIDTH{bus.sub}};
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                fa_en = 1'b1;
                // Sum fills from the MSB side so bit 0 lands in place after WIDTH shifts.
                sum_d = {fa_s, sum_q[WIDTH-1:1]};
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.busy = (state_q == ST_RUN);
    assign bus.done = (state_q == ST_DONE);
    assign bus.sum  = sum_q;
    // Carry flops freeze outside RUN, so these hold from Done until the next accepted Start.
    assign bus.cout = carry_q;
    assign bus.ovf  = carry_q ^ carry_in_q;
endmodule
